// File: rtl/pci_pkg.sv
// ---------------------------------------------------------------------------
// pci_pkg
//   Definitions shared by the PCI initiator and target on the common bus:
//   memory command codes, active-low level names and the target FSM states.
//   The WR_WAIT/RD_WAIT states are only reached when the target is built
//   with PCI_TGT_WAIT_EN defined.
// ---------------------------------------------------------------------------
package pci_pkg;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    BUSY,
    WR_WAIT,
    WR_DATA,
    RD_TA,
    RD_WAIT,
    RD_DATA,
    TURN
  } tgt_state_e;

endpackage

// File: rtl/pci_tgt_mem.sv
// ---------------------------------------------------------------------------
// pci_tgt_mem
//   DEPTH x 32-bit data buffer for the PCI target (DEPTH = 2**ADDR_W).
//   Contents are not reset.
// Ports
//   clk_i    bus clock
//   we_i     write strobe, sampled on the rising edge
//   be_i     active-high byte write enables
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index (asynchronous read)
//   rdata_o  read data
// ---------------------------------------------------------------------------
module pci_tgt_mem #(
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pci_target.sv
// ---------------------------------------------------------------------------
// pci_target
//   PCI memory target. Claims MEM_RD/MEM_WR cycles whose address falls in
//   the DEPTH-word window at BASE_ADDR and moves burst data to/from a small
//   word-addressed buffer. The word pointer wraps inside the window.
//   Optional: define PCI_TGT_WAIT_EN to insert one trdy wait state before
//   the first data phase of every claimed cycle.
// Ports
//   clk     bus clock (rising edge)
//   rst_n   asynchronous active-low reset
//   ad      multiplexed address/data, driven only in read data phases
//   c_be    command (address phase) / active-low byte enables (data phases)
//   frame   active-low cycle frame from the initiator
//   irdy    active-low initiator ready
//   devsel  active-low device select
//   trdy    active-low target ready
// ---------------------------------------------------------------------------
module pci_target
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          ADDR_W    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [31:0] ad,
  input  logic [3:0]  c_be,
  input  logic        frame,
  input  logic        irdy,
  output logic        devsel,
  output logic        trdy
);

  tgt_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ad_oe;
  logic              mem_we;
  logic [31:0]       rdata;
  logic              hit;
  logic              unused_ad;

  // Address bits below the word index carry no meaning for this target.
  assign unused_ad = ^ad[1:0];

  assign hit = (ad[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) &&
               ((c_be == CMD_MEM_RD) || (c_be == CMD_MEM_WR));

  // The command is latched implicitly: a hit branches into the write or the
  // read state path, so the state itself remembers the direction.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    devsel  = DEASSERTED;
    trdy    = DEASSERTED;
    ad_oe   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame == ASSERTED) begin
          if (hit) begin
            ptr_d = ad[ADDR_W+1:2];
            if (c_be == CMD_MEM_WR) begin
`ifdef PCI_TGT_WAIT_EN
              state_d = WR_WAIT;
`else
              state_d = WR_DATA;
`endif
            end else begin
              state_d = RD_TA;
            end
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if ((frame == DEASSERTED) && (irdy == DEASSERTED)) begin
          state_d = IDLE;
        end
      end
`ifdef PCI_TGT_WAIT_EN
      WR_WAIT: begin
        devsel = ASSERTED;
        if ((frame == DEASSERTED) && (irdy == DEASSERTED)) begin
          state_d = TURN;
        end else begin
          state_d = WR_DATA;
        end
      end
      RD_WAIT: begin
        devsel = ASSERTED;
        ad_oe  = 1'b1;
        if ((frame == DEASSERTED) && (irdy == DEASSERTED)) begin
          state_d = TURN;
        end else begin
          state_d = RD_DATA;
        end
      end
`endif
      WR_DATA: begin
        devsel = ASSERTED;
        trdy   = ASSERTED;
        // frame high ends the cycle whether or not this edge transfers.
        if (irdy == ASSERTED) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + ADDR_W'(1);
        end
        if (frame == DEASSERTED) begin
          state_d = TURN;
        end
      end
      RD_TA: begin
        devsel = ASSERTED;
        if ((frame == DEASSERTED) && (irdy == DEASSERTED)) begin
          state_d = TURN;
        end else begin
`ifdef PCI_TGT_WAIT_EN
          state_d = RD_WAIT;
`else
          state_d = RD_DATA;
`endif
        end
      end
      RD_DATA: begin
        devsel = ASSERTED;
        trdy   = ASSERTED;
        ad_oe  = 1'b1;
        if (irdy == ASSERTED) begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
        if (frame == DEASSERTED) begin
          state_d = TURN;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  pci_tgt_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .be_i    (~c_be),
    .waddr_i (ptr_q),
    .wdata_i (ad),
    .raddr_i (ptr_q),
    .rdata_o (rdata)
  );

  assign ad = ad_oe ? rdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_pci_target.sv
// ---------------------------------------------------------------------------
// tb_pci_target
//   Self-checking bench for pci_target. A behavioural initiator drives
//   address/data phases; a model of the 4-word buffer (with per-byte known
//   masks) feeds a scoreboard queue of expected read words. ad carries a
//   pullup so a released bus reads as all ones.
// ---------------------------------------------------------------------------
module tb_pci_target;
  import pci_pkg::*;

`ifdef PCI_TGT_WAIT_EN
  localparam int WAITC = 1;
`else
  localparam int WAITC = 0;
`endif
  localparam int MAXC = 16;

  typedef struct {
    logic [31:0] d;
    logic [31:0] m;
  } sbEntry_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  c_be;
  logic        frame;
  logic        irdy;
  logic        devsel;
  logic        trdy;
  logic [31:0] adDrv;
  logic        adOe;
  wire  [31:0] ad;

  int          compared;
  int          mismatched;
  sbEntry_t    sbQ[$];
  logic [31:0] model [4];
  logic [31:0] known [4];
  logic [31:0] wrData [8];
  logic [3:0]  wrBe [8];
  bit          inWait;
  bit          waited;

  assign ad = adOe ? adDrv : 32'hzzzz_zzzz;
  pullup (ad);

  pci_target dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ad     (ad),
    .c_be   (c_be),
    .frame  (frame),
    .irdy   (irdy),
    .devsel (devsel),
    .trdy   (trdy)
  );

  // Free-running 100 MHz bus clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Puts the initiator's side of data phase idx on the bus, optionally
  // inserting a single initiator wait cycle (irdy high, frame held low).
  task automatic setupPhase(input int idx, input int n, input int waitAt, input bit isRd);
    if (idx == waitAt && !waited) begin
      irdy   = 1'b1;
      frame  = 1'b0;
      inWait = 1'b1;
      waited = 1'b1;
    end else begin
      irdy   = 1'b0;
      inWait = 1'b0;
      frame  = (idx == n - 1);
    end
    if (!isRd) begin
      adDrv = wrData[idx];
      c_be  = wrBe[idx];
    end
  endtask

  // Runs one bus transaction of n data phases. Reads push expected words to
  // the scoreboard up front; writes update the model at each transfer.
  // abortAfter >= 0 pulls rst_n low mid-cycle after that many transfers.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] addr, input int n,
                               input int waitAt, input bit hit, input int abortAfter);
    bit       isRd;
    bit       xferNow;
    bit       aborted;
    int       idx;
    int       k;
    int       firstTrdy;
    int       base;
    int       p;
    sbEntry_t e;
    isRd      = (cmd == CMD_MEM_RD);
    aborted   = 1'b0;
    base      = int'(addr[3:2]);
    @(posedge clk); #1;
    frame = 1'b0; irdy = 1'b1; c_be = cmd; adDrv = addr; adOe = 1'b1;
    if (isRd && hit) begin
      for (int i = 0; i < n; i++) begin
        e.d = model[(base + i) % 4];
        e.m = known[(base + i) % 4];
        sbQ.push_back(e);
      end
    end
    @(posedge clk); #1;
    if (isRd) begin
      adOe = 1'b0;
      c_be = 4'b0000;
    end
    idx = 0; k = 1; firstTrdy = 0; waited = 1'b0;
    setupPhase(idx, n, waitAt, isRd);
    while (idx < n) begin
      @(negedge clk);
      if (idx == abortAfter) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rstDevsel", 32'(devsel), 32'(1));
        checkOutput("rstTrdy", 32'(trdy), 32'(1));
        checkOutput("rstAdRelease", ad, 32'hFFFF_FFFF);
        aborted = 1'b1;
        break;
      end
      if (k == 1) checkOutput("devselAfterAddr", 32'(devsel), hit ? 32'(0) : 32'(1));
      if (!hit) begin
        checkOutput("missDevsel", 32'(devsel), 32'(1));
        checkOutput("missTrdy", 32'(trdy), 32'(1));
      end
      if (hit && trdy == 1'b0 && firstTrdy == 0) begin
        firstTrdy = k;
        checkOutput(isRd ? "rdTrdyLatency" : "wrTrdyLatency", 32'(k), 32'((isRd ? 2 : 1) + WAITC));
      end
      if (inWait) checkOutput("initWaitTrdyHeld", 32'(trdy), 32'(0));
      xferNow = (trdy == 1'b0) && (irdy == 1'b0);
      if (xferNow && isRd) begin
        if (sbQ.size() == 0) begin
          checkOutput("sbUnderflow", 32'(1), 32'(0));
        end else begin
          e = sbQ.pop_front();
          checkOutput("rdData", ad & e.m, e.d & e.m);
        end
      end
      if (xferNow && !isRd) begin
        p = (base + idx) % 4;
        for (int b = 0; b < 4; b++) begin
          if (!wrBe[idx][b]) begin
            model[p][8*b +: 8] = wrData[idx][8*b +: 8];
            known[p][8*b +: 8] = 8'hFF;
          end
        end
      end
      if (!hit && k >= 4) break;
      if (k >= MAXC) begin
        checkOutput("timeoutTransfers", 32'(idx), 32'(n));
        break;
      end
      @(posedge clk); #1;
      k++;
      if (xferNow) idx++;
      if (idx < n) setupPhase(idx, n, waitAt, isRd);
    end
    #1;
    frame = 1'b1; irdy = 1'b1; adOe = 1'b0; c_be = 4'b0000;
    if (aborted) begin
      sbQ.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else if (hit) begin
      @(negedge clk);
      checkOutput("turnDevsel", 32'(devsel), 32'(1));
      checkOutput("turnTrdy", 32'(trdy), 32'(1));
      checkOutput("turnAdRelease", ad, 32'hFFFF_FFFF);
    end else begin
      repeat (2) @(posedge clk);
    end
  endtask

  // Main sequence: reset checks, then the directed bus scenarios.
  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b1; frame = 1'b1; irdy = 1'b1; c_be = 4'b0000;
    adDrv = 32'h0; adOe = 1'b0; inWait = 1'b0; waited = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model[i] = 32'h0;
      known[i] = 32'h0;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("resetDevsel", 32'(devsel), 32'(1));
    checkOutput("resetTrdy", 32'(trdy), 32'(1));
    checkOutput("resetAd", ad, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Asynchronous reset while idle, then hold after release.
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("idleRstDevsel", 32'(devsel), 32'(1));
    checkOutput("idleRstTrdy", 32'(trdy), 32'(1));
    checkOutput("idleRstAd", ad, 32'hFFFF_FFFF);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstDevsel", 32'(devsel), 32'(1));
    checkOutput("postRstTrdy", 32'(trdy), 32'(1));
    checkOutput("postRstAd", ad, 32'hFFFF_FFFF);

    // Partial-byte write then single read of the same word.
    wrData[0] = 32'hBBBB_DFBB; wrBe[0] = 4'b0100;
    applyStimulus(CMD_MEM_WR, 32'h0000_1004, 1, -1, 1'b1, -1);
    applyStimulus(CMD_MEM_RD, 32'h0000_1004, 1, -1, 1'b1, -1);

    // Three-word burst write, burst read back with an initiator wait.
    wrData[0] = 32'hAAAA_AAAA; wrData[1] = 32'hBBBB_DFBB; wrData[2] = 32'h1234_5678;
    wrBe[0] = 4'b0000; wrBe[1] = 4'b0000; wrBe[2] = 4'b0000;
    applyStimulus(CMD_MEM_WR, 32'h0000_1000, 3, -1, 1'b1, -1);
    applyStimulus(CMD_MEM_RD, 32'h0000_1000, 3, 1, 1'b1, -1);

    // Out-of-window write is ignored; buffer is checked afterwards.
    wrData[0] = 32'hDEAD_BEEF; wrBe[0] = 4'b0000;
    applyStimulus(CMD_MEM_WR, 32'h0000_2000, 1, -1, 1'b0, -1);
    applyStimulus(CMD_MEM_RD, 32'h0000_1000, 3, -1, 1'b1, -1);

    // Burst starting at the last word wraps to word 0.
    wrData[0] = 32'h1111_1111; wrData[1] = 32'h2222_2222;
    wrBe[0] = 4'b0000; wrBe[1] = 4'b0000;
    applyStimulus(CMD_MEM_WR, 32'h0000_100C, 2, -1, 1'b1, -1);
    applyStimulus(CMD_MEM_RD, 32'h0000_100C, 2, -1, 1'b1, -1);
    applyStimulus(CMD_MEM_RD, 32'h0000_1000, 4, -1, 1'b1, -1);

    // Reset in the middle of a read burst, then a fresh claimed cycle.
    applyStimulus(CMD_MEM_RD, 32'h0000_1000, 3, -1, 1'b1, 1);
    wrData[0] = 32'h5A5A_5A5A; wrBe[0] = 4'b0000;
    applyStimulus(CMD_MEM_WR, 32'h0000_1008, 1, -1, 1'b1, -1);
    applyStimulus(CMD_MEM_RD, 32'h0000_1008, 1, -1, 1'b1, -1);

    checkOutput("sbDrained", 32'(sbQ.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
